// File: rtl/ps2_cmd_ctrl.sv
// PS/2 host command sequencer: sends a command (and optional argument) byte,
// waits for ACK (FA), retransmits on Resend (FE), reports done/error and
// forwards all non-protocol receive bytes to the keyboard decoder.
// Optional feature macro: PS2_CMD_BAT_EN (wait for BAT result AA after FF).
module ps2_cmd_ctrl #(
    parameter int unsigned ACK_TIMEOUT = 2_000_000,
    parameter int unsigned MAX_RETRY   = 3,
    parameter int unsigned BAT_TIMEOUT = 100_000_000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       cmd_valid,
    input  logic [7:0] cmd_byte,
    input  logic       cmd_has_arg,
    input  logic [7:0] cmd_arg,
    output logic       cmd_ready,
    output logic       cmd_done,
    output logic       cmd_err,
    output logic [1:0] err_code,
    output logic [7:0] tx_byte,
    output logic       tx_wr,
    input  logic       tx_idle,
    input  logic       tx_finished,
    input  logic [7:0] rx_byte,
    input  logic       rx_done,
    output logic [7:0] key_byte,
    output logic       key_valid
);

    localparam int unsigned TMAX = (ACK_TIMEOUT > BAT_TIMEOUT) ? ACK_TIMEOUT : BAT_TIMEOUT;
    localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam int unsigned RW   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [TW-1:0] ACK_LAST = TW'(ACK_TIMEOUT - 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

    localparam logic [7:0] B_ACK    = 8'hFA;
    localparam logic [7:0] B_RESEND = 8'hFE;
    localparam logic [7:0] B_DEVERR = 8'hFC;
`ifdef PS2_CMD_BAT_EN
    localparam logic [TW-1:0] BAT_LAST = TW'(BAT_TIMEOUT - 1);
    localparam logic [7:0] B_BAT_OK = 8'hAA;
    localparam logic [7:0] B_RESET  = 8'hFF;
`endif

    localparam logic [1:0] E_NONE    = 2'b00;
    localparam logic [1:0] E_TIMEOUT = 2'b01;
    localparam logic [1:0] E_RETRY   = 2'b10;
    localparam logic [1:0] E_DEVICE  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT_TX,
        S_WAIT_ACK,
`ifdef PS2_CMD_BAT_EN
        S_WAIT_BAT,
`endif
        S_DONE,
        S_ERR
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    cmd_q, cmd_d;
    logic [7:0]    arg_q, arg_d;
    logic          has_arg_q, has_arg_d;
    logic          phase_q, phase_d;      // 0 = command byte, 1 = argument byte
    logic [RW-1:0] retry_q, retry_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [1:0]    err_code_q, err_code_d;
    logic [7:0]    tx_byte_q, tx_byte_d;
    logic          tx_wr_q, tx_wr_d;
    logic          cmd_ready_q, cmd_ready_d;
    logic          cmd_done_q, cmd_done_d;
    logic          cmd_err_q, cmd_err_d;
    logic [7:0]    key_byte_q, key_byte_d;
    logic          key_valid_q, key_valid_d;
    logic          fwd;

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            cmd_q       <= 8'h00;
            arg_q       <= 8'h00;
            has_arg_q   <= 1'b0;
            phase_q     <= 1'b0;
            retry_q     <= '0;
            tcnt_q      <= '0;
            err_code_q  <= E_NONE;
            tx_byte_q   <= 8'h00;
            tx_wr_q     <= 1'b0;
            cmd_ready_q <= 1'b1;
            cmd_done_q  <= 1'b0;
            cmd_err_q   <= 1'b0;
            key_byte_q  <= 8'h00;
            key_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            arg_q       <= arg_d;
            has_arg_q   <= has_arg_d;
            phase_q     <= phase_d;
            retry_q     <= retry_d;
            tcnt_q      <= tcnt_d;
            err_code_q  <= err_code_d;
            tx_byte_q   <= tx_byte_d;
            tx_wr_q     <= tx_wr_d;
            cmd_ready_q <= cmd_ready_d;
            cmd_done_q  <= cmd_done_d;
            cmd_err_q   <= cmd_err_d;
            key_byte_q  <= key_byte_d;
            key_valid_q <= key_valid_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        arg_d       = arg_q;
        has_arg_d   = has_arg_q;
        phase_d     = phase_q;
        retry_d     = retry_q;
        tcnt_d      = tcnt_q;
        err_code_d  = err_code_q;
        tx_byte_d   = tx_byte_q;
        tx_wr_d     = 1'b0;
        key_byte_d  = key_byte_q;
        key_valid_d = 1'b0;
        fwd         = 1'b0;

        case (state_q)
            S_IDLE: begin
                fwd = rx_done;
                if (cmd_valid && cmd_ready_q) begin
                    cmd_d      = cmd_byte;
                    arg_d      = cmd_arg;
                    has_arg_d  = cmd_has_arg;
                    phase_d    = 1'b0;
                    retry_d    = '0;
                    err_code_d = E_NONE;
                    state_d    = S_LOAD;
                end
            end
            S_LOAD: begin
                fwd = rx_done;
                if (tx_idle) begin
                    tx_wr_d   = 1'b1;
                    tx_byte_d = phase_q ? arg_q : cmd_q;
                    state_d   = S_WAIT_TX;
                end
            end
            S_WAIT_TX: begin
                if (tx_finished) begin
                    tcnt_d  = '0;
                    state_d = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                if (tcnt_q != ACK_LAST) begin
                    tcnt_d = tcnt_q + TW'(1);
                end
                if (rx_done) begin
                    case (rx_byte)
                        B_ACK: begin
                            if (!phase_q && has_arg_q) begin
                                phase_d = 1'b1;
                                retry_d = '0;
                                state_d = S_LOAD;
`ifdef PS2_CMD_BAT_EN
                            end else if (!phase_q && cmd_q == B_RESET) begin
                                tcnt_d  = '0;
                                state_d = S_WAIT_BAT;
`endif
                            end else begin
                                state_d = S_DONE;
                            end
                        end
                        B_RESEND: begin
                            if (retry_q == RETRY_MAX) begin
                                err_code_d = E_RETRY;
                                state_d    = S_ERR;
                            end else begin
                                retry_d = retry_q + RW'(1);
                                state_d = S_LOAD;
                            end
                        end
                        B_DEVERR: begin
                            err_code_d = E_DEVICE;
                            state_d    = S_ERR;
                        end
                        default: fwd = 1'b1;
                    endcase
                end else if (tcnt_q == ACK_LAST) begin
                    err_code_d = E_TIMEOUT;
                    state_d    = S_ERR;
                end
            end
`ifdef PS2_CMD_BAT_EN
            S_WAIT_BAT: begin
                if (tcnt_q != BAT_LAST) begin
                    tcnt_d = tcnt_q + TW'(1);
                end
                if (rx_done) begin
                    if (rx_byte == B_BAT_OK) begin
                        state_d = S_DONE;
                    end else if (rx_byte == B_DEVERR) begin
                        err_code_d = E_DEVICE;
                        state_d    = S_ERR;
                    end else begin
                        fwd = 1'b1;
                    end
                end else if (tcnt_q == BAT_LAST) begin
                    err_code_d = E_TIMEOUT;
                    state_d    = S_ERR;
                end
            end
`endif
            S_DONE: begin
                fwd     = rx_done;
                state_d = S_IDLE;
            end
            S_ERR: begin
                fwd     = rx_done;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (fwd) begin
            key_valid_d = 1'b1;
            key_byte_d  = rx_byte;
        end

        cmd_ready_d = (state_d == S_IDLE);
        cmd_done_d  = (state_d == S_DONE);
        cmd_err_d   = (state_d == S_ERR);
    end

    assign cmd_ready = cmd_ready_q;
    assign cmd_done  = cmd_done_q;
    assign cmd_err   = cmd_err_q;
    assign err_code  = err_code_q;
    assign tx_byte   = tx_byte_q;
    assign tx_wr     = tx_wr_q;
    assign key_byte  = key_byte_q;
    assign key_valid = key_valid_q;

endmodule

// File: tb/tb_ps2_cmd_ctrl.sv
// Self-checking bench for ps2_cmd_ctrl: table of command transactions plus
// hand-written sequences for reset, exact timeout latency, IDLE forwarding
// and the FF/AA (BAT) handling in either build of PS2_CMD_BAT_EN.
module tb_ps2_cmd_ctrl;

    logic       clk;
    logic       reset_n;
    logic       cmd_valid;
    logic [7:0] cmd_byte;
    logic       cmd_has_arg;
    logic [7:0] cmd_arg;
    logic       cmd_ready;
    logic       cmd_done;
    logic       cmd_err;
    logic [1:0] err_code;
    logic [7:0] tx_byte;
    logic       tx_wr;
    logic       tx_idle;
    logic       tx_finished;
    logic [7:0] rx_byte;
    logic       rx_done;
    logic [7:0] key_byte;
    logic       key_valid;

    ps2_cmd_ctrl #(
        .ACK_TIMEOUT(100),
        .MAX_RETRY  (3),
        .BAT_TIMEOUT(300)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cmd_valid  (cmd_valid),
        .cmd_byte   (cmd_byte),
        .cmd_has_arg(cmd_has_arg),
        .cmd_arg    (cmd_arg),
        .cmd_ready  (cmd_ready),
        .cmd_done   (cmd_done),
        .cmd_err    (cmd_err),
        .err_code   (err_code),
        .tx_byte    (tx_byte),
        .tx_wr      (tx_wr),
        .tx_idle    (tx_idle),
        .tx_finished(tx_finished),
        .rx_byte    (rx_byte),
        .rx_done    (rx_done),
        .key_byte   (key_byte),
        .key_valid  (key_valid)
    );

    typedef struct packed {
        logic [7:0]      cmd;
        logic            has_arg;
        logic [7:0]      arg;
        logic [7:0]      pre_key;   // non-protocol byte injected before first reply
        logic [2:0]      nrep;
        logic [0:4][7:0] rep;       // device reply after each strobe; 00 = silence
        logic [2:0]      nstb;
        logic [0:4][7:0] exp_tx;
        logic            exp_done;
        logic [1:0]      exp_code;
    } vec_t;

    vec_t vecs [7];

    int n_cmp = 0;
    int n_bad = 0;
    int strobes = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int key_cnt = 0;
    logic [7:0] tx_log [$];
    logic [7:0] key_log [$];

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Output monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (reset_n) begin
            if (tx_wr) begin
                strobes++;
                tx_log.push_back(tx_byte);
            end
            if (cmd_done) done_cnt++;
            if (cmd_err) err_cnt++;
            if (key_valid) begin
                key_cnt++;
                key_log.push_back(key_byte);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [7:0] c, input logic ha, input logic [7:0] a,
                                input logic [7:0] pk, input logic [2:0] nr, input logic [39:0] r,
                                input logic [2:0] ns, input logic [39:0] tx,
                                input logic d, input logic [1:0] code);
        vec_t m;
        m.cmd = c;  m.has_arg = ha; m.arg = a; m.pre_key = pk;
        m.nrep = nr; m.rep = r; m.nstb = ns; m.exp_tx = tx;
        m.exp_done = d; m.exp_code = code;
        return m;
    endfunction

    task automatic send_rx(input logic [7:0] b);
        @(posedge clk); #1 rx_byte = b; rx_done = 1'b1;
        @(posedge clk); #1 rx_done = 1'b0;
    endtask

    task automatic pulse_fin();
        @(posedge clk); #1 tx_finished = 1'b1;
        @(posedge clk); #1 tx_finished = 1'b0;
    endtask

    task automatic accept(input logic [7:0] c, input logic ha, input logic [7:0] a);
        @(posedge clk); #1 cmd_valid = 1'b1; cmd_byte = c; cmd_has_arg = ha; cmd_arg = a;
        @(posedge clk); #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_stb(input int target);
        for (int k = 0; k < 50 && strobes < target; k++) @(negedge clk);
        check("strobe_arrives", 32'(strobes >= target), 32'd1);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int b_stb, b_done, b_err, b_key;
        b_stb = strobes; b_done = done_cnt; b_err = err_cnt; b_key = key_cnt;
        accept(v.cmd, v.has_arg, v.arg);
        for (int i = 0; i < int'(v.nrep); i++) begin
            wait_stb(b_stb + i + 1);
            pulse_fin();
            repeat (2) @(posedge clk);
            if (i == 0 && v.pre_key != 8'h00) begin
                send_rx(v.pre_key);
                repeat (2) @(posedge clk);
            end
            if (v.rep[i] != 8'h00) send_rx(v.rep[i]);
        end
        for (int k = 0; k < 400 && (done_cnt + err_cnt) == (b_done + b_err); k++) @(negedge clk);
        repeat (5) @(negedge clk);
        $display("vector %0d cmd %0h", idx, v.cmd);
        check("strobe_count", 32'(strobes - b_stb), 32'(v.nstb));
        for (int j = 0; j < int'(v.nstb); j++) begin
            if (b_stb + j < tx_log.size())
                check("strobe_byte", 32'(tx_log[b_stb + j]), 32'(v.exp_tx[j]));
        end
        check("done_count", 32'(done_cnt - b_done), 32'(v.exp_done));
        check("err_count", 32'(err_cnt - b_err), 32'(!v.exp_done));
        check("err_code", 32'(err_code), 32'(v.exp_code));
        check("key_count", 32'(key_cnt - b_key), (v.pre_key != 8'h00) ? 32'd1 : 32'd0);
        if (v.pre_key != 8'h00 && b_key < key_log.size())
            check("key_byte_fwd", 32'(key_log[b_key]), 32'(v.pre_key));
    endtask

    initial begin
        int n, b_done, b_err, b_key, b_stb;
        reset_n = 1'b0; cmd_valid = 1'b0; cmd_byte = 8'h00; cmd_has_arg = 1'b0; cmd_arg = 8'h00;
        tx_idle = 1'b1; tx_finished = 1'b0; rx_byte = 8'h00; rx_done = 1'b0;

        vecs[0] = mk(8'hF4, 1'b0, 8'h00, 8'h00, 3'd1, {8'hFC, 32'h0}, 3'd1, {8'hF4, 32'h0}, 1'b0, 2'b11);
        vecs[1] = mk(8'hED, 1'b1, 8'h07, 8'h00, 3'd2, {8'hFA, 8'hFA, 24'h0}, 3'd2, {8'hED, 8'h07, 24'h0}, 1'b1, 2'b00);
        vecs[2] = mk(8'hF4, 1'b0, 8'h00, 8'h00, 3'd4, {8'hFE, 8'hFE, 8'hFE, 8'hFA, 8'h0}, 3'd4, {8'hF4, 8'hF4, 8'hF4, 8'hF4, 8'h0}, 1'b1, 2'b00);
        vecs[3] = mk(8'hF4, 1'b0, 8'h00, 8'h00, 3'd4, {8'hFE, 8'hFE, 8'hFE, 8'hFE, 8'h0}, 3'd4, {8'hF4, 8'hF4, 8'hF4, 8'hF4, 8'h0}, 1'b0, 2'b10);
        vecs[4] = mk(8'hF4, 1'b0, 8'h00, 8'h00, 3'd1, {8'h00, 32'h0}, 3'd1, {8'hF4, 32'h0}, 1'b0, 2'b01);
        vecs[5] = mk(8'hF3, 1'b1, 8'h20, 8'h00, 3'd3, {8'hFA, 8'hFE, 8'hFA, 16'h0}, 3'd3, {8'hF3, 8'h20, 8'h20, 16'h0}, 1'b1, 2'b00);
        vecs[6] = mk(8'hF4, 1'b0, 8'h00, 8'h1C, 3'd1, {8'hFA, 32'h0}, 3'd1, {8'hF4, 32'h0}, 1'b1, 2'b00);

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_tx_wr", 32'(tx_wr), 32'd0);
        check("rst_tx_byte", 32'(tx_byte), 32'd0);
        check("rst_err_code", 32'(err_code), 32'd0);
        check("rst_key_byte", 32'(key_byte), 32'd0);
        check("rst_pulses", 32'({cmd_done, cmd_err, key_valid}), 32'd0);
        @(posedge clk); #1 reset_n = 1'b1;

        // Table-driven transactions
        for (int i = 0; i < 7; i++) begin
            run_vec(i, vecs[i]);
            repeat (3) @(posedge clk);
        end

        // Exact timeout latency: cmd_err 100 edges after tx_finished is sampled
        accept(8'hF4, 1'b0, 8'h00);
        wait_stb(strobes + 1);
        @(posedge clk); #1 tx_finished = 1'b1;
        @(posedge clk);
        #1 tx_finished = 1'b0;
        n = 0;
        while (n < 300) begin
            @(negedge clk);
            if (cmd_err) break;
            @(posedge clk);
            n++;
        end
        check("timeout_latency", 32'(n), 32'd100);
        check("timeout_code", 32'(err_code), 32'd1);
        repeat (3) @(posedge clk);

        // Reset during WAIT_ACK
        accept(8'hF4, 1'b0, 8'h00);
        wait_stb(strobes + 1);
        pulse_fin();
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b0;
        b_done = done_cnt; b_err = err_cnt;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        check("mid_rst_ready", 32'(cmd_ready), 32'd1);
        check("mid_rst_pulses", 32'({tx_wr, cmd_done, cmd_err}), 32'd0);
        check("mid_rst_code", 32'(err_code), 32'd0);
        repeat (150) @(negedge clk);
        check("mid_rst_no_events", 32'((done_cnt - b_done) + (err_cnt - b_err)), 32'd0);

        // IDLE forwarding, including a stray FA
        @(posedge clk); #1 rx_byte = 8'h1C; rx_done = 1'b1;
        @(posedge clk); #1 rx_done = 1'b0;
        @(negedge clk);
        check("idle_fwd_valid", 32'(key_valid), 32'd1);
        check("idle_fwd_byte", 32'(key_byte), 32'h1C);
        @(negedge clk);
        check("idle_fwd_pulse_end", 32'(key_valid), 32'd0);
        b_key = key_cnt;
        send_rx(8'hFA);
        repeat (2) @(negedge clk);
        check("idle_stray_fa", 32'(key_cnt - b_key), 32'd1);

        // FF then FA then AA; transmitter busy at first
        b_done = done_cnt; b_key = key_cnt; b_stb = strobes;
        @(posedge clk); #1 tx_idle = 1'b0;
        accept(8'hFF, 1'b0, 8'h00);
        repeat (5) @(negedge clk);
        check("load_waits_tx_idle", 32'(strobes - b_stb), 32'd0);
        @(posedge clk); #1 tx_idle = 1'b1;
        wait_stb(b_stb + 1);
        if (b_stb < tx_log.size()) check("ff_strobe_byte", 32'(tx_log[b_stb]), 32'hFF);
        pulse_fin();
        repeat (2) @(posedge clk);
        send_rx(8'hFA);
        repeat (4) @(negedge clk);
`ifdef PS2_CMD_BAT_EN
        check("ff_done_after_fa", 32'(done_cnt - b_done), 32'd0);
`else
        check("ff_done_after_fa", 32'(done_cnt - b_done), 32'd1);
`endif
        send_rx(8'hAA);
        repeat (4) @(negedge clk);
        check("ff_done_total", 32'(done_cnt - b_done), 32'd1);
`ifdef PS2_CMD_BAT_EN
        check("ff_aa_forward", 32'(key_cnt - b_key), 32'd0);
`else
        check("ff_aa_forward", 32'(key_cnt - b_key), 32'd1);
        if (b_key < key_log.size()) check("ff_aa_byte", 32'(key_log[b_key]), 32'hAA);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
